condition_unit: RTL and testbench

CONDITION_UNIT -- requirements
Module: condition_unit

---
 rtl/condition_unit.sv | 202 ++++++++++++++++++++
 tb/tb_condition_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/condition_unit.sv
`default_nettype none
// ============================================================================
//  Module      : condition_unit
//  Description : NZCV flag register, registered condition-code evaluator and
//                predicated-window (IT-block style) sequencer that produces a
//                per-instruction execute enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module condition_unit #(
    parameter int COND_WIDTH = 6,
    parameter int IT_DEPTH   = 4,
    parameter int BYPASS     = 1,
    localparam int LEN_W     = $clog2(IT_DEPTH + 1),
    localparam int SLOT_W    = $clog2(IT_DEPTH)
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  flags_we_i,
    input  logic [3:0]            flags_mask_i,
    input  logic [3:0]            flags_in_i,
    output logic [3:0]            flags_o,
    input  logic                  eval_valid_i,
    input  logic [COND_WIDTH-1:0] eval_cond_i,
    output logic                  take_valid_o,
    output logic                  take_o,
    input  logic                  it_start_i,
    input  logic [COND_WIDTH-1:0] it_cond_i,
    input  logic [LEN_W-1:0]      it_len_i,
    input  logic [IT_DEPTH-1:0]   it_pattern_i,
    input  logic                  instr_step_i,
    output logic                  it_active_o,
    output logic [SLOT_W-1:0]     it_slot_o,
    output logic                  exec_en_o,
    output logic                  it_error_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Condition table on {N,Z,C,V}; codes of 16 and above never pass.
    function automatic logic cond_eval(input logic [COND_WIDTH-1:0] code,
                                       input logic [3:0]            f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        r = 1'b0;
        if ({1'b0, code} <= (COND_WIDTH + 1)'(15)) begin
            unique case (code[3:0])
                4'd0:    r = z;
                4'd1:    r = ~z;
                4'd2:    r = c;
                4'd3:    r = ~c;
                4'd4:    r = n;
                4'd5:    r = ~n;
                4'd6:    r = v;
                4'd7:    r = ~v;
                4'd8:    r = c & ~z;
                4'd9:    r = ~c | z;
                4'd10:   r = (n == v);
                4'd11:   r = (n != v);
                4'd12:   r = ~z & (n == v);
                4'd13:   r = z | (n != v);
                default: r = 1'b1;
            endcase
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Flag register and effective (optionally bypassed) flags
    // ------------------------------------------------------------------
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] eff_flags;

    assign flags_d = flags_we_i ? ((flags_q & ~flags_mask_i) | (flags_in_i & flags_mask_i))
                                : flags_q;

    generate
        if (BYPASS != 0) begin : g_bypass
            assign eff_flags = flags_d;
        end else begin : g_no_bypass
            assign eff_flags = flags_q;
        end
    endgenerate

    // Flag state: masked load on write strobe, hold otherwise.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) flags_q <= 4'b0000;
        else           flags_q <= flags_d;
    end

    // ------------------------------------------------------------------
    // Registered condition evaluation; result holds between requests
    // ------------------------------------------------------------------
    logic take_q;
    logic take_valid_q;

    // One-cycle evaluation pipeline.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            take_valid_q <= 1'b0;
            take_q       <= 1'b0;
        end else begin
            take_valid_q <= eval_valid_i;
            if (eval_valid_i) take_q <= cond_eval(eval_cond_i, eff_flags);
        end
    end

    // ------------------------------------------------------------------
    // Predicated window sequencer
    // ------------------------------------------------------------------
    logic [0:0]            state_q,   state_d;
    logic [SLOT_W-1:0]     slot_q,    slot_d;
    logic [COND_WIDTH-1:0] cond_q,    cond_d;
    logic [LEN_W-1:0]      len_q,     len_d;
    logic [IT_DEPTH-1:0]   pat_q,     pat_d;
    logic                  err_q,     err_d;
    logic                  len_ok;
    logic                  last_slot;

    assign len_ok    = (it_len_i != '0) && (it_len_i <= LEN_W'(IT_DEPTH));
    assign last_slot = ((LEN_W'(slot_q) + LEN_W'(1)) == len_q);

    // State register; reset abandons any open window immediately.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            cond_q  <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cond_q  <= cond_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
        end
    end

    // Next-state: open window on a legal start, step slots, flag bad starts.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cond_d  = cond_q;
        len_d   = len_q;
        pat_d   = pat_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                // A step arriving with the start belongs to the preceding
                // instruction, so the window always opens at slot 0.
                if (it_start_i) begin
                    if (len_ok) begin
                        state_d = ST_ACTIVE;
                        slot_d  = '0;
                        cond_d  = it_cond_i;
                        len_d   = it_len_i;
                        pat_d   = it_pattern_i | IT_DEPTH'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (it_start_i) err_d = 1'b1;
                if (instr_step_i) begin
                    if (last_slot) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: enable is live-evaluated each cycle against the effective flags;
    // "else" slots invert the result, so always-true conditions disable them.
    always_comb begin
        it_active_o = (state_q == ST_ACTIVE);
        exec_en_o   = 1'b1;
        if (state_q == ST_ACTIVE) begin
            exec_en_o = cond_eval(cond_q, eff_flags) ^ ~pat_q[slot_q];
        end
    end

    assign flags_o      = flags_q;
    assign take_o       = take_q;
    assign take_valid_o = take_valid_q;
    assign it_slot_o    = slot_q;
    assign it_error_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_condition_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_condition_unit
//  Description : Self-checking bench for condition_unit; take results are
//                checked through an expected-value queue drained by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_condition_unit;

    localparam int CW = 6;
    localparam int D  = 4;
    localparam int LW = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flags_we;
    logic [3:0]    flags_mask;
    logic [3:0]    flags_in;
    logic          eval_valid;
    logic [CW-1:0] eval_cond;
    logic          it_start;
    logic [CW-1:0] it_cond;
    logic [LW-1:0] it_len;
    logic [D-1:0]  it_pattern;
    logic          instr_step;

    logic [3:0]    flags_o, flags0_o;
    logic          take_valid_o, take_valid0_o;
    logic          take_o, take0_o;
    logic          it_active_o, it_active0_o;
    logic [SW-1:0] it_slot_o, it_slot0_o;
    logic          exec_en_o, exec_en0_o;
    logic          it_error_o, it_error0_o;

    int  n_cmp  = 0;
    int  n_fail = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    condition_unit #(.COND_WIDTH(CW), .IT_DEPTH(D), .BYPASS(1)) u_dut (
        .clock_i(clk), .reset_ni(rst_n),
        .flags_we_i(flags_we), .flags_mask_i(flags_mask), .flags_in_i(flags_in),
        .flags_o(flags_o),
        .eval_valid_i(eval_valid), .eval_cond_i(eval_cond),
        .take_valid_o(take_valid_o), .take_o(take_o),
        .it_start_i(it_start), .it_cond_i(it_cond), .it_len_i(it_len),
        .it_pattern_i(it_pattern), .instr_step_i(instr_step),
        .it_active_o(it_active_o), .it_slot_o(it_slot_o),
        .exec_en_o(exec_en_o), .it_error_o(it_error_o)
    );

    condition_unit #(.COND_WIDTH(CW), .IT_DEPTH(D), .BYPASS(0)) u_dut_nb (
        .clock_i(clk), .reset_ni(rst_n),
        .flags_we_i(flags_we), .flags_mask_i(flags_mask), .flags_in_i(flags_in),
        .flags_o(flags0_o),
        .eval_valid_i(eval_valid), .eval_cond_i(eval_cond),
        .take_valid_o(take_valid0_o), .take_o(take0_o),
        .it_start_i(it_start), .it_cond_i(it_cond), .it_len_i(it_len),
        .it_pattern_i(it_pattern), .instr_step_i(instr_step),
        .it_active_o(it_active0_o), .it_slot_o(it_slot0_o),
        .exec_en_o(exec_en0_o), .it_error_o(it_error0_o)
    );

    // Reference condition table written from the {N,Z,C,V} definitions.
    function automatic logic ref_cond(input int code, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            15: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Execute one window slot: check enable and slot index, then retire it.
    task automatic do_slot(input string name, input logic exp_exec, input logic [SW-1:0] exp_slot);
        instr_step = 1'b1;
        @(negedge clk);
        chk({name, "_exec"}, exec_en_o, exp_exec);
        chk({name, "_slot"}, it_slot_o, exp_slot);
        tick();
        instr_step = 1'b0;
    endtask

    // Monitor: every presented take result is matched against the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && take_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL take_unexpected: take_valid=1 but no result was expected");
            end else begin
                chk("take", take_o, exp_q.pop_front());
            end
        end
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int code;
        rst_n = 1'b0; flags_we = 0; flags_mask = 0; flags_in = 0;
        eval_valid = 0; eval_cond = 0; it_start = 0; it_cond = 0;
        it_len = 0; it_pattern = 0; instr_step = 0;

        // Reset values
        #3;
        chk("rst_flags", flags_o, 0);
        chk("rst_take", take_o, 0);
        chk("rst_take_valid", take_valid_o, 0);
        chk("rst_active", it_active_o, 0);
        chk("rst_slot", it_slot_o, 0);
        chk("rst_error", it_error_o, 0);
        chk("rst_exec", exec_en_o, 1);
        #9 rst_n = 1'b1;
        tick();

        // Table sweep over all flag values and codes 0..15, 16, 63
        for (int f = 0; f < 16; f++) begin
            flags_we = 1; flags_mask = 4'hF; flags_in = f[3:0];
            tick();
            flags_we = 0;
            chk("flags_load", flags_o, f);
            for (int k = 0; k < 18; k++) begin
                code = (k < 16) ? k : ((k == 16) ? 16 : 63);
                eval_valid = 1; eval_cond = code[CW-1:0];
                exp_q.push_back(ref_cond(code, f[3:0]));
                tick();
            end
            eval_valid = 0;
        end

        // take holds while no request is made (flags=1111, AL -> 1)
        eval_valid = 1; eval_cond = 14; exp_q.push_back(1'b1);
        tick();
        eval_valid = 0; eval_cond = 63;
        tick();
        chk("take_hold", take_o, 1);
        chk("take_valid_low", take_valid_o, 0);

        // Bypass: same-cycle Z write seen only by the bypassing instance
        flags_we = 1; flags_mask = 4'hF; flags_in = 4'h0;
        tick();
        flags_mask = 4'b0100; flags_in = 4'b0100;
        eval_valid = 1; eval_cond = 0; exp_q.push_back(1'b1);
        tick();
        flags_we = 0; eval_valid = 0;
        chk("nobypass_take", take0_o, 0);
        chk("flags_after_bypass", flags_o, 4'b0100);

        // Partial mask: only N and V change
        flags_we = 1; flags_mask = 4'b1001; flags_in = 4'b1111;
        tick();
        chk("flags_mask", flags_o, 4'b1101);
        flags_mask = 4'hF; flags_in = 4'b0100;
        tick();
        flags_we = 0;

        // Window EQ, len 3, pattern then/else/then with Z=1 -> 1,0,1
        it_start = 1; it_cond = 0; it_len = 3; it_pattern = 4'b0101;
        tick();
        it_start = 0;
        chk("win1_active", it_active_o, 1);
        do_slot("win1_s0", 1, 0);
        do_slot("win1_s1", 0, 1);
        do_slot("win1_s2", 1, 2);
        chk("win1_done_active", it_active_o, 0);
        chk("win1_done_exec", exec_en_o, 1);

        // Same window with bit 0 given as else (forced then); Z cleared in slot 1
        it_start = 1; it_cond = 0; it_len = 3; it_pattern = 4'b0100;
        tick();
        it_start = 0;
        do_slot("win2_s0", 1, 0);
        flags_we = 1; flags_mask = 4'b0100; flags_in = 4'b0000;
        @(negedge clk);
        chk("win2_s1_bypass_exec", exec_en_o, 1);
        tick();
        flags_we = 0;
        do_slot("win2_s1", 1, 1);
        do_slot("win2_s2", 0, 2);
        chk("win2_done_active", it_active_o, 0);

        // AL window opened together with a step: step must not advance the slot
        it_start = 1; it_cond = 14; it_len = 2; it_pattern = 4'b0001; instr_step = 1;
        tick();
        it_start = 0; instr_step = 0;
        chk("win3_active", it_active_o, 1);
        do_slot("win3_s0", 1, 0);
        do_slot("win3_else", 0, 1);
        chk("win3_done_active", it_active_o, 0);
        chk("no_error_yet", it_error_o, 0);

        // Error: zero-length start
        it_start = 1; it_cond = 0; it_len = 0; it_pattern = 4'b0001;
        tick();
        it_start = 0;
        chk("err_len0_error", it_error_o, 1);
        chk("err_len0_active", it_active_o, 0);

        // Error: start while active leaves the window unchanged
        it_start = 1; it_cond = 14; it_len = 2; it_pattern = 4'b0011;
        tick();
        it_cond = 63; it_len = 4; it_pattern = 4'b0000;
        tick();
        it_start = 0;
        chk("err_busy_active", it_active_o, 1);
        chk("err_busy_error", it_error_o, 1);
        do_slot("err_busy_s0", 1, 0);
        do_slot("err_busy_s1", 1, 1);
        chk("err_busy_done", it_active_o, 0);

        // Reset mid-window in slot 2 of 4
        flags_we = 1; flags_mask = 4'hF; flags_in = 4'hF;
        tick();
        flags_we = 0;
        it_start = 1; it_cond = 0; it_len = 4; it_pattern = 4'b1111;
        tick();
        it_start = 0;
        do_slot("rstwin_s0", 1, 0);
        do_slot("rstwin_s1", 1, 1);
        chk("rstwin_pre_slot", it_slot_o, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwin_active", it_active_o, 0);
        chk("rstwin_slot", it_slot_o, 0);
        chk("rstwin_flags", flags_o, 0);
        chk("rstwin_error", it_error_o, 0);
        chk("rstwin_exec", exec_en_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_active", it_active_o, 0);

        // Error: length beyond depth
        it_start = 1; it_cond = 0; it_len = 5; it_pattern = 4'b0001;
        tick();
        it_start = 0;
        chk("err_len5_error", it_error_o, 1);
        chk("err_len5_active", it_active_o, 0);

        tick();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL take_drain: %0d expected results never presented, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
